// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared types and defaults for the bit serializer
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_serializer_cnt.sv
// rtl/bit_serializer_cnt.sv - bit position counter, saturating at WIDTH-1
module bit_serializer_cnt
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last = (count_q == CW'(WIDTH - 1));

  // Holding at WIDTH-1 means only a clear can wrap the count back to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !last) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel word to serial bit stream with back-to-back reload
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic             head_bit;
  logic             last;
  logic             advance;
  logic             accept;

  generate
    if (MSB_FIRST) begin : g_msb
      assign head_bit     = sreg_q[WIDTH-1];
      assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head_bit     = sreg_q[0];
      assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  // shift_en only matters while a word is held.
  assign advance    = (state_q == SHIFT) && shift_en;
  assign done       = !sys_rst && advance && last;
  assign load_ready = !sys_rst && ((state_q == IDLE) || (advance && last));
  assign accept     = load_valid && load_ready;

  assign out_valid  = (state_q == SHIFT);
  assign out        = out_valid && head_bit;

  bit_serializer_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .clr  (accept || done),
    .en   (advance),
    .last (last)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = load_data;
    end else if (done) begin
      state_d = IDLE;
      sreg_d  = '0;
    end else if (advance) begin
      sreg_d  = sreg_shifted;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench driving MSB-first and LSB-first instances in lockstep
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         lv;
  logic         se;
  logic [W-1:0] ld;

  logic rdy_m, out_m, ov_m, done_m;
  logic rdy_l, out_l, ov_l, done_l;

  logic q_m[$];
  logic q_l[$];

  int   checks    = 0;
  int   errors    = 0;
  int   done_seen = 0;
  logic acc_last  = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .load_valid (lv),
    .load_data  (ld),
    .load_ready (rdy_m),
    .shift_en   (se),
    .out        (out_m),
    .out_valid  (ov_m),
    .done       (done_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .load_valid (lv),
    .load_data  (ld),
    .load_ready (rdy_l),
    .shift_en   (se),
    .out        (out_l),
    .out_valid  (ov_l),
    .done       (done_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic rm, rl, acc;
    #1;
    rm = !rst && (q_m.size() == 0 || (q_m.size() == 1 && se));
    rl = !rst && (q_l.size() == 0 || (q_l.size() == 1 && se));
    chk("valid_msb", ov_m, q_m.size() != 0);
    if (q_m.size() != 0) chk("out_msb", out_m, q_m[0]);
    chk("ready_msb", rdy_m, rm);
    chk("done_msb", done_m, !rst && q_m.size() == 1 && se);
    chk("valid_lsb", ov_l, q_l.size() != 0);
    if (q_l.size() != 0) chk("out_lsb", out_l, q_l[0]);
    chk("ready_lsb", rdy_l, rl);
    chk("done_lsb", done_l, !rst && q_l.size() == 1 && se);
    if (done_m === 1'b1) done_seen++;
    acc      = lv && rm;
    acc_last = acc;
    @(posedge clk);
    if (rst) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (q_m.size() != 0 && se) void'(q_m.pop_front());
      if (q_l.size() != 0 && se) void'(q_l.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) q_m.push_back(ld[i]);
        for (int i = 0; i < W; i++) q_l.push_back(ld[i]);
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic offer(input logic [W-1:0] d);
    lv = 1'b1;
    ld = d;
    acc_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_last) break;
    end
    if (!acc_last) chk("accept_timeout", 1'b0, 1'b1);
    lv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lv  = 1'b0;
    se  = 1'b1;
    ld  = '0;
    @(posedge clk);
    #1;
    run(2);

    rst = 1'b0;
    done_seen = 0;
    offer(8'b01010110);
    run(10);
    chk("single_done_count", done_seen == 1, 1'b1);

    done_seen = 0;
    offer(8'hA5);
    offer(8'h3C);
    run(9);
    chk("b2b_done_count", done_seen == 2, 1'b1);

    offer(8'hF0);
    run(3);
    se = 1'b0;
    run(3);
    se = 1'b1;
    run(6);

    done_seen = 0;
    offer(8'hC3);
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("reset_no_done", done_seen == 0, 1'b1);
    offer(8'h96);
    run(9);

    offer(8'h12);
    offer(8'hFF);
    run(9);

    se = 1'b0;
    offer(8'h5A);
    run(2);
    se = 1'b1;
    run(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which is the number of bits per parallel word; the legal range SHALL be 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 SHALL mean bit WIDTH-1 is emitted first, 0 SHALL mean bit 0 is emitted first.
REQ-003 Port sys_clk SHALL be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-004 Port sys_rst SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-005 Port load_valid SHALL be an input, 1 bit wide: upstream offers load_data.
REQ-006 Port load_data SHALL be an input, WIDTH bits wide: the parallel word to serialize.
REQ-007 Port load_ready SHALL be an output, 1 bit wide: the block can accept a word this cycle.
REQ-008 Port shift_en SHALL be an input, 1 bit wide: when high, the serial stream advances; when low, it stalls.
REQ-009 Port out SHALL be an output, 1 bit wide: the serial bit, which drives the downstream sequence detector's in.
REQ-010 Port out_valid SHALL be an output, 1 bit wide: out carries a data bit this cycle.
REQ-011 Port done SHALL be an output, 1 bit wide: a one-cycle pulse on the cycle in which the last bit of a word is consumed.

Function
REQ-012 The block SHALL have two states:
- IDLE: no word held.
- SHIFT: a word is held and its bits are being presented.
REQ-013 A word SHALL be accepted on a rising edge where load_valid and load_ready are both 1; acceptance SHALL latch load_data into the shift register and reset the bit counter to 0.
REQ-014 load_ready SHALL be 1 when the state is IDLE.
REQ-015 load_ready SHALL also be 1 in SHIFT when the counter equals WIDTH-1 and shift_en is 1; it SHALL be 0 otherwise.
REQ-016 The cycle after acceptance, the state SHALL be SHIFT, out_valid SHALL be 1, and out SHALL be the first bit, giving one cycle of latency.
REQ-017 In SHIFT, on an edge with shift_en=1, the next bit SHALL be presented and the counter SHALL increment.
REQ-018 In SHIFT, on an edge with shift_en=0, out, out_valid and the counter SHALL hold.
REQ-019 When the counter equals WIDTH-1 and shift_en=1, done SHALL be 1 in that cycle.
REQ-020 At that last-bit edge (REQ-019), if a new word is accepted, the block SHALL remain in SHIFT and present the new word's first bit with no gap cycle.
REQ-021 At that last-bit edge (REQ-019), if no new word is accepted, the block SHALL go to IDLE.
REQ-022 In IDLE, out SHALL be 0, out_valid SHALL be 0 and done SHALL be 0.
REQ-023 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1; wrap-around SHALL occur only through REQ-013.
REQ-024 load_valid asserted in SHIFT while load_ready=0 SHALL have no effect; upstream SHALL hold the word until accepted.
REQ-025 shift_en SHALL be ignored in IDLE; acceptance in IDLE SHALL NOT depend on shift_en.

Reset
REQ-026 While sys_rst=1 at a rising edge, the next state SHALL be IDLE, the counter SHALL be 0, the shift register SHALL be 0, and out, out_valid and done SHALL be 0.
REQ-027 While sys_rst=1, load_ready SHALL be 0.
REQ-028 Reset asserted mid-word SHALL discard the remaining bits, and no done pulse SHALL be produced for that word.
REQ-029 The first acceptance SHALL be possible on the first edge after sys_rst deasserts.

Structure
REQ-030 A shared package bit_serializer_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-031 A sub-module bit_serializer_cnt SHALL implement the bit counter with clear, enable and last outputs.
REQ-032 The datapath SHALL be a shift register whose direction is selected by MSB_FIRST at elaboration time.

Verification
REQ-033 Scenario: reset, then load 8'b01010110 with shift_en held at 1 -> out=0,1,0,1,0,1,1,0 with out_valid=1 on 8 consecutive cycles starting one cycle after acceptance; done=1 on the 8th cycle; IDLE afterwards.
REQ-034 Scenario: back-to-back load of 8'hA5 then 8'h3C, with the second offered during the last bit of the first -> 16 contiguous out_valid cycles, output 10100101 then 00111100; done pulses twice.
REQ-035 Scenario: shift_en=0 for 3 cycles after the 3rd bit of 8'hF0 -> out holds 1 for those 3 extra cycles; the full word is still 11110000 with no lost or duplicated bit.
REQ-036 Scenario: sys_rst=1 after the 4th bit of a word -> out_valid=0 the next cycle; no done pulse; the next loaded word serializes correctly from its first bit.
REQ-037 Scenario: load_valid=1 with 8'hFF while in mid-word -> load_ready=0 and the current word is unaffected; 8'hFF is accepted at the last bit.
REQ-038 Scenario: MSB_FIRST=0, load 8'b01010110 -> out=0,1,1,0,1,0,1,0.
